// File: rtl/bus2st_ser.sv
// Parallel bus to Avalon-ST serializer: FIFO-buffered bus words emitted LSB-first as ST-bit symbols, framed into turbo packets.
// Optional BUS2ST_CREDIT_EN adds pkt_credit, a one-cycle pulse after each eop handshake.
//   state | meaning
//   IDLE  | no word in service; loads FIFO head into sh when FIFO non-empty
//   ARM   | word loaded, raising st_valid on the next edge
//   SEND  | presenting symbols; streams straight into the next word when one is queued
module bus2st_ser #(
    parameter int BUS_W                 = 512,
    parameter int ST                    = 8,
    parameter int NUM_ST_PER_BUS        = BUS_W / ST,
    parameter int NUM_BUS_PER_TURBO_PKT = 2,
    parameter int BUF_WORDS             = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] bus_data,
    input  logic             bus_en,
    output logic             bus_ready,
    output logic [ST-1:0]    st_data,
    output logic             st_valid,
    output logic             st_sop,
    output logic             st_eop,
    input  logic             st_ready,
    output logic             bus_ovf
`ifdef BUS2ST_CREDIT_EN
    ,
    output logic             pkt_credit
`endif
);

    localparam int SYM_W = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
    localparam int WRD_W = $clog2(NUM_BUS_PER_TURBO_PKT) + 1;
    localparam int PTR_W = $clog2(BUF_WORDS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_ST_PER_BUS - 1);
    localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(NUM_BUS_PER_TURBO_PKT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, SEND} state_t;

    state_t             state;
    logic [BUS_W-1:0]   mem [BUF_WORDS];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_nxt;
    logic [CNT_W-1:0]   count;
    logic [BUS_W-1:0]   sh;
    logic [SYM_W-1:0]   sym_cnt;
    logic [WRD_W-1:0]   word_cnt;
    logic               push;
    logic               hs;
    logic               retire;
    logic               has_next;

    // The word being serialized keeps its FIFO slot until its last symbol is accepted.
    assign bus_ready = (count != CNT_FULL);
    assign push      = bus_en && bus_ready;
    assign hs        = st_valid && st_ready;
    assign retire    = hs && (sym_cnt == SYM_LAST);
    assign has_next  = (count > CNT_ONE);
    assign rd_nxt    = rd_ptr + 1'b1;

    assign st_data = sh[ST-1:0];
    assign st_sop  = st_valid && (word_cnt == '0) && (sym_cnt == '0);
    assign st_eop  = st_valid && (word_cnt == WRD_LAST) && (sym_cnt == SYM_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sh       <= '0;
            sym_cnt  <= '0;
            word_cnt <= '0;
            st_valid <= 1'b0;
            bus_ovf  <= 1'b0;
        end else begin
            if (bus_en && !bus_ready) begin
                bus_ovf <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_nxt;
            end
            case ({push, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    st_valid <= 1'b0;
                    if (count != '0) begin
                        sh      <= mem[rd_ptr];
                        sym_cnt <= '0;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    st_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        if (sym_cnt == SYM_LAST) begin
                            sym_cnt  <= '0;
                            word_cnt <= (word_cnt == WRD_LAST) ? '0 : word_cnt + 1'b1;
                            if (has_next) begin
                                sh <= mem[rd_nxt];
                            end else begin
                                sh       <= sh >> ST;
                                st_valid <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            sh      <= sh >> ST;
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    st_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef BUS2ST_CREDIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_credit <= 1'b0;
        end else begin
            pkt_credit <= hs && st_eop;
        end
    end
`endif

endmodule

// File: tb/tb_bus2st_ser.sv
// Bench for bus2st_ser: symbol-queue scoreboard plus directed tests for reset, streaming, backpressure, overflow and mid-packet reset.
// Define BUS2ST_CREDIT_EN to also check pkt_credit.
module tb_bus2st_ser;

    localparam int BUS_W = 512;
    localparam int ST    = 8;
    localparam int NSYM  = 64;
    localparam int NPKT  = 2;
    localparam int BUFW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [BUS_W-1:0] bus_data;
    logic             bus_en;
    logic             bus_ready;
    logic [ST-1:0]    st_data;
    logic             st_valid;
    logic             st_sop;
    logic             st_eop;
    logic             st_ready;
    logic             bus_ovf;
`ifdef BUS2ST_CREDIT_EN
    logic             pkt_credit;
`endif

    always #5 clk = ~clk;

    bus2st_ser #(
        .BUS_W(BUS_W), .ST(ST), .NUM_ST_PER_BUS(NSYM),
        .NUM_BUS_PER_TURBO_PKT(NPKT), .BUF_WORDS(BUFW)
    ) dut (
        .clk(clk), .rst(rst), .bus_data(bus_data), .bus_en(bus_en),
        .bus_ready(bus_ready), .st_data(st_data), .st_valid(st_valid),
        .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready), .bus_ovf(bus_ovf)
`ifdef BUS2ST_CREDIT_EN
        , .pkt_credit(pkt_credit)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       last;
    } sym_t;

    sym_t       exp_q[$];
    int         occ = 0;
    int         wpos = 0;
    logic       m_ovf = 1'b0;
    logic       m_credit = 1'b0;
    int         n_checks = 0;
    int         n_err = 0;
    int         n_hs = 0;
    int         n_sop = 0;
    int         n_eop = 0;
    int         n_cred = 0;
    logic [7:0] last_d = '0;
    logic       hold = 1'b0;
    logic [7:0] p_d;
    logic       p_sop, p_eop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted word becomes NSYM expected symbols; framing follows arrival order.
    task automatic model_push(input logic [BUS_W-1:0] w);
        sym_t e;
        for (int k = 0; k < NSYM; k++) begin
            e.d    = w[8*k +: 8];
            e.sop  = (wpos == 0) && (k == 0);
            e.eop  = (wpos == NPKT - 1) && (k == NSYM - 1);
            e.last = (k == NSYM - 1);
            exp_q.push_back(e);
        end
        wpos = (wpos + 1) % NPKT;
    endtask

    // Checks outputs held since the last edge, then applies the upcoming edge to the model.
    always @(negedge clk) begin
        sym_t e;
        int   occ_pre;
        chk("bus_ready", 32'(bus_ready), 32'(occ != BUFW));
        chk("bus_ovf", 32'(bus_ovf), 32'(m_ovf));
`ifdef BUS2ST_CREDIT_EN
        chk("pkt_credit", 32'(pkt_credit), 32'(m_credit));
        n_cred += 32'(pkt_credit);
`endif
        if (hold) begin
            chk("hold_valid", 32'(st_valid), 32'd1);
            chk("hold_data", 32'(st_data), 32'(p_d));
            chk("hold_sop", 32'(st_sop), 32'(p_sop));
            chk("hold_eop", 32'(st_eop), 32'(p_eop));
        end
        if (st_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL stale_sym: got data %0h with nothing expected at %0t", st_data, $time);
            end else begin
                e = exp_q[0];
                chk("st_data", 32'(st_data), 32'(e.d));
                chk("st_sop", 32'(st_sop), 32'(e.sop));
                chk("st_eop", 32'(st_eop), 32'(e.eop));
            end
        end else begin
            chk("sop_idle", 32'(st_sop), 32'd0);
            chk("eop_idle", 32'(st_eop), 32'd0);
        end

        hold = 1'b0;
        if (rst) begin
            exp_q.delete();
            occ      = 0;
            wpos     = 0;
            m_ovf    = 1'b0;
            m_credit = 1'b0;
        end else begin
            occ_pre  = occ;
            m_credit = 1'b0;
            if (st_valid && st_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_hs++;
                n_sop += 32'(st_sop);
                n_eop += 32'(st_eop);
                last_d = st_data;
                if (e.last) occ--;
                m_credit = e.eop;
            end
            if (bus_en) begin
                if (occ_pre != BUFW) begin
                    model_push(bus_data);
                    occ++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            hold  = st_valid && !st_ready;
            p_d   = st_data;
            p_sop = st_sop;
            p_eop = st_eop;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] mk_word(input int base, input int step);
        logic [BUS_W-1:0] w;
        for (int k = 0; k < NSYM; k++) w[8*k +: 8] = 8'(base + k * step);
        return w;
    endfunction

    task automatic push(input logic [BUS_W-1:0] w, input logic rnd);
        bus_en   = 1'b1;
        bus_data = w;
        if (rnd) st_ready = 1'($urandom_range(0, 1));
        cyc();
        bus_en = 1'b0;
    endtask

    task automatic run_hs(input int n, input int maxc, input logic rnd, output int got);
        int base = n_hs;
        for (int c = 0; c < maxc && (n_hs - base) < n; c++) begin
            st_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
        end
        got = n_hs - base;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int got, cnt, s0, e0, run, idx;
        logic started;
        logic [BUS_W-1:0] w5 [6];

        // T1: reset held two cycles while bus_en is asserted
        rst = 1'b1; bus_en = 1'b1; bus_data = mk_word(8'h33, 1); st_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0; bus_en = 1'b0;
        chk("t1_valid", 32'(st_valid), 0);
        chk("t1_ovf", 32'(bus_ovf), 0);
        chk("t1_ready", 32'(bus_ready), 1);
        chk("t1_data", 32'(st_data), 0);
        chk("t1_sop", 32'(st_sop), 0);
        chk("t1_eop", 32'(st_eop), 0);
        st_ready = 1'b1;
        repeat (4) cyc();
        chk("t1_nostore", 32'(st_valid), 0);

        // T2: one packet, sink always ready; latency and contiguity
        s0 = n_sop; e0 = n_eop;
        push(mk_word(0, 1), 1'b0);
        push(mk_word(64, 1), 1'b0);
        chk("t2_lat1", 32'(st_valid), 0);
        cyc();
        chk("t2_lat2", 32'(st_valid), 1);
        chk("t2_first", 32'(st_data), 32'h00);
        chk("t2_first_sop", 32'(st_sop), 1);
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (st_valid) cnt++;
            else if (cnt > 0) break;
            cyc();
        end
        chk("t2_len", cnt, 128);
        chk("t2_sops", n_sop - s0, 1);
        chk("t2_eops", n_eop - e0, 1);
        chk("t2_last", 32'(last_d), 32'h7F);

        // T3: same packet under random backpressure
        s0 = n_sop; e0 = n_eop;
        push(mk_word(0, 1), 1'b1);
        push(mk_word(64, 1), 1'b1);
        run_hs(128, 2000, 1'b1, got);
        chk("t3_count", got, 128);
        chk("t3_sops", n_sop - s0, 1);
        chk("t3_eops", n_eop - e0, 1);
        chk("t3_last", 32'(last_d), 32'h7F);
        st_ready = 1'b1;
        repeat (4) cyc();

        // T4: fill with sink stalled; fifth word must be dropped
        st_ready = 1'b0;
        s0 = n_sop; e0 = n_eop;
        for (int i = 0; i < 4; i++) begin
            push(mk_word(16 * i + 5, 3), 1'b0);
            chk("t4_ready", 32'(bus_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        push(mk_word(8'hEE, 0), 1'b0);
        chk("t4_ovf", 32'(bus_ovf), 1);
        repeat (3) cyc();
        chk("t4_ovf_sticky", 32'(bus_ovf), 1);
        run_hs(256, 600, 1'b0, got);
        chk("t4_count", got, 256);
        chk("t4_sops", n_sop - s0, 2);
        chk("t4_eops", n_eop - e0, 2);
        repeat (5) cyc();
        chk("t4_no_fifth", 32'(st_valid), 0);
        chk("t4_ovf_end", 32'(bus_ovf), 1);

        // T5: three packets back to back, no bubbles
        for (int i = 0; i < 6; i++) w5[i] = mk_word(i * 40 + 1, i + 1);
        s0 = n_sop; e0 = n_eop;
        idx = 0; run = 0; started = 1'b0;
        st_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (idx < 6 && bus_ready) begin
                bus_en = 1'b1; bus_data = w5[idx]; idx++;
            end else begin
                bus_en = 1'b0;
            end
            cyc();
            if (st_valid) begin
                started = 1'b1;
                run++;
            end else if (started) begin
                break;
            end
        end
        bus_en = 1'b0;
        chk("t5_run", run, 384);
        chk("t5_sops", n_sop - s0, 3);
        chk("t5_eops", n_eop - e0, 3);
        repeat (3) cyc();
`ifdef BUS2ST_CREDIT_EN
        chk("credit_total", n_cred, 7);
`endif

        // T6: reset after 70 symbols, then a fresh packet
        push(mk_word(8'h10, 1), 1'b0);
        push(mk_word(8'h50, 1), 1'b0);
        run_hs(70, 300, 1'b0, got);
        chk("t6_reach", got, 70);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_valid", 32'(st_valid), 0);
        chk("t6_ready", 32'(bus_ready), 1);
        chk("t6_ovf", 32'(bus_ovf), 0);
        repeat (3) cyc();
        chk("t6_quiet", 32'(st_valid), 0);
        s0 = n_sop; e0 = n_eop; cnt = n_cred;
        push(mk_word(8'h90, 1), 1'b0);
        push(mk_word(8'hD0, 1), 1'b0);
        cyc();
        chk("t6_first_valid", 32'(st_valid), 1);
        chk("t6_first_data", 32'(st_data), 32'h90);
        chk("t6_first_sop", 32'(st_sop), 1);
        run_hs(128, 300, 1'b0, got);
        chk("t6_count", got, 128);
        chk("t6_sops", n_sop - s0, 1);
        chk("t6_eops", n_eop - e0, 1);
        chk("t6_last", 32'(last_d), 32'h0F);
        repeat (4) cyc();
`ifdef BUS2ST_CREDIT_EN
        chk("t6_credit", n_cred - cnt, 1);
`endif
        chk("t6_idle", 32'(st_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
